// File: rtl/tt_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, control FSM states and the
// default operand width.
package tt_alu_pkg;

  localparam int WIDTH_DEF = 7;

  typedef enum logic [2:0] {
    OP_LDA = 3'd0,
    OP_LDB = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// clock. done is a one-cycle strobe aligned with the final step so the caller
// captures res_hi/res_lo on the same edge that busy falls.
module alu_muldiv_unit
  import tt_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             div_mode,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   m_q;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;

  assign busy   = (state == ST_RUN);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign done   = busy && last;
  assign res_hi = hi_n;
  assign res_lo = lo_n;

  // MUL: hi is the running accumulator, lo holds the multiplier and fills with
  // product bits. DIV: hi is the partial remainder, lo shifts the dividend out
  // and quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m_q});
    hi_n      = hi_q;
    lo_n      = lo_q;
    if (div_mode) begin
      hi_n = div_ge ? WIDTH'(div_shift - {1'b0, m_q}) : div_shift[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      div_mode <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            cnt      <= '0;
            hi_q     <= '0;
            div_mode <= div;
            lo_q     <= div ? a : b;
            m_q      <= div ? b : a;
          end
        end
        ST_RUN: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_nishit0072e_seq_alu.sv
// Sequential ALU top: strobe synchroniser, command decode, operand/result
// registers and flags. MUL and non-zero DIV run in alu_muldiv_unit.
module tt_um_nishit0072e_seq_alu
  import tt_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int PAD = 8 - WIDTH;

  logic             s1, s2, s3;
  logic             sync_ok;
  logic             armed;
  logic             accept;
  logic             md_start;
  opcode_e          op;
  logic [WIDTH-1:0] data;
  logic             hi_sel;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             zero_q, carry_q, done_q;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH:0]   alu_diff;
  logic [WIDTH-1:0] alu_res;

  logic             md_busy, md_div, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic             unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in, uio_in[7:4]};

  assign op     = opcode_e'(uio_in[2:0]);
  assign data   = ui_in[WIDTH-1:0];
  assign hi_sel = ui_in[7];

  // A strobe already high when reset lifts must be seen low once before any
  // rising edge counts, so armed waits for a genuine low sample.
  assign accept   = s2 && !s3 && !md_busy && armed;
  assign md_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b_q != '0)));

  assign alu_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign alu_diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = alu_sum[WIDTH-1:0];
      OP_SUB:  alu_res = alu_diff[WIDTH-1:0];
      OP_AND:  alu_res = a_q & b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .div      (op == OP_DIV),
    .a        (a_q),
    .b        (b_q),
    .busy     (md_busy),
    .div_mode (md_div),
    .done     (md_done),
    .res_hi   (md_hi),
    .res_lo   (md_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      sync_ok <= 1'b0;
      armed   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      s1      <= uio_in[3];
      s2      <= s1;
      s3      <= s2;
      sync_ok <= 1'b1;
      if (sync_ok && !s1) begin
        armed <= 1'b1;
      end

      if (md_done) begin
        res_hi  <= md_hi;
        res_lo  <= md_lo;
        carry_q <= md_div ? 1'b0 : (md_hi != '0);
        zero_q  <= md_div ? (md_lo == '0) : ((md_hi == '0) && (md_lo == '0));
        done_q  <= 1'b1;
      end else if (accept) begin
        done_q <= 1'b1;
        case (op)
          OP_LDA: a_q <= data;
          OP_LDB: b_q <= data;
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            res_lo  <= alu_res;
            res_hi  <= '0;
            zero_q  <= (alu_res == '0);
            carry_q <= (op == OP_ADD) ? alu_sum[WIDTH] :
                       (op == OP_SUB) ? alu_diff[WIDTH] : 1'b0;
          end
          OP_MUL: done_q <= 1'b0;
          OP_DIV: begin
            if (b_q == '0) begin
              res_lo  <= '1;
              res_hi  <= a_q;
              carry_q <= 1'b1;
              zero_q  <= 1'b0;
            end else begin
              done_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign uo_out  = hi_sel ? {{PAD{1'b0}}, res_hi} : {{PAD{1'b0}}, res_lo};
  assign uio_out = {md_busy, done_q, zero_q, carry_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_nishit0072e_seq_alu.sv
// Scoreboard bench: the driver issues random and directed commands and queues
// the expected result; a negedge monitor compares when each result is due.
module tb_tt_um_nishit0072e_seq_alu;

  localparam int W = 7;
  localparam int M = 1 << W;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int lo;
    int hi;
    bit z;
    bit c;
    bit multi;
    bit sel;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference state: operands and last visible results
  int ma, mb, mlo, mhi;
  bit mz, mc;

  tt_um_nishit0072e_seq_alu #(.WIDTH(W)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mlo = 0; mhi = 0; mz = 0; mc = 0;
  endtask

  task automatic issue(input int op, input int data, input bit sel, input bit intrude);
    exp_t e;
    int   k;
    int   p;
    bit   multi;
    multi = 0;
    @(posedge clk);
    #1;
    ui_in  = {sel, data[6:0]};
    uio_in = {4'h0, 1'b1, op[2:0]};
    k = cyc + 1;
    case (op)
      0: ma = data;
      1: mb = data;
      2: begin p = ma + mb; mlo = p % M; mhi = 0; mc = (p >= M); mz = (mlo == 0); end
      3: begin mlo = (ma - mb + M) % M; mhi = 0; mc = (ma < mb); mz = (mlo == 0); end
      4: begin mlo = ma & mb; mhi = 0; mc = 0; mz = (mlo == 0); end
      5: begin mlo = ma ^ mb; mhi = 0; mc = 0; mz = (mlo == 0); end
      6: begin
        p = ma * mb; mlo = p % M; mhi = p / M; mc = (mhi != 0); mz = (p == 0); multi = 1;
      end
      default: begin
        if (mb == 0) begin
          mlo = M - 1; mhi = ma; mc = 1; mz = 0;
        end else begin
          mlo = ma / mb; mhi = ma % mb; mc = 0; mz = (mlo == 0); multi = 1;
        end
      end
    endcase
    e.lo = mlo; e.hi = mhi; e.z = mz; e.c = mc; e.multi = multi; e.sel = sel;
    e.due = multi ? k + 2 + W : k + 2;
    sbq.push_back(e);
    if (intrude && multi) begin
      // A fresh ADD strobe rising while the unit is busy must be dropped
      wait_cyc(k + 2);
      uio_in = {4'h0, 1'b0, 3'd2};
      wait_cyc(k + 4);
      uio_in[3] = 1'b1;
      wait_cyc(k + 6);
      uio_in[3] = 1'b0;
    end
    wait_cyc(e.due);
    @(negedge clk);
    #1;
    uio_in[3] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq[0];
      if (mon_e.multi) begin
        if (cyc == mon_e.due - W - 1) chk("busy_before_accept", int'(uio_out[7]), 0);
        if (cyc == mon_e.due - W)     chk("busy_at_accept", int'(uio_out[7]), 1);
        if (cyc == mon_e.due - 1) begin
          chk("busy_last_iter", int'(uio_out[7]), 1);
          chk("done_low_while_busy", int'(uio_out[6]), 0);
        end
      end
      if (cyc == mon_e.due) begin
        void'(sbq.pop_front());
        chk(mon_e.sel ? "result_hi" : "result_lo", int'(uo_out),
            mon_e.sel ? mon_e.hi : mon_e.lo);
        chk("flags_busy_done_zero_carry", int'(uio_out[7:4]),
            int'({2'b01, mon_e.z, mon_e.c}));
        chk("uio_low_nibble", int'(uio_out[3:0]), 0);
      end else if (cyc > mon_e.due) begin
        void'(sbq.pop_front());
        chk("missed_response", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    #3;
    chk("reset_uo_out", int'(uo_out), 0);
    chk("reset_uio_out", int'(uio_out), 0);
    chk("uio_oe", int'(uio_oe), 8'hF0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Directed arithmetic
    issue(0, 100, 0, 0);
    issue(1, 27, 0, 0);
    issue(2, 0, 0, 0);
    chk("add_127", int'(uo_out), 127);
    issue(0, 5, 0, 0);
    issue(1, 9, 0, 0);
    issue(3, 0, 0, 0);
    chk("sub_borrow_lo", int'(uo_out), 124);
    chk("sub_borrow_c", int'(uio_out[4]), 1);
    issue(0, 9, 0, 0);
    issue(3, 0, 0, 0);
    chk("sub_zero_flag", int'(uio_out[5]), 1);

    // MUL with an intruding strobe, then hi_sel viewing
    issue(0, 100, 0, 0);
    issue(1, 27, 0, 0);
    issue(6, 0, 0, 1);
    ui_in[7] = 1'b1;
    #1;
    chk("mul_hi_view", int'(uo_out), 21);
    ui_in[7] = 1'b0;
    #1;
    chk("mul_lo_view", int'(uo_out), 12);
    chk("mul_done_sticky", int'(uio_out[6]), 1);

    issue(7, 0, 1, 0);
    chk("div_rem_view", int'(uo_out), 19);
    issue(1, 0, 0, 0);
    issue(7, 0, 1, 0);
    chk("div0_hi_view", int'(uo_out), 100);

    // Random commands
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a MUL, with the strobe held across release
    issue(0, 100, 0, 0);
    issue(1, 27, 0, 0);
    @(posedge clk);
    #1;
    uio_in = {4'h0, 1'b1, 3'd6};
    k = cyc + 1;
    wait_cyc(k + 4);
    chk("busy_mid_mul", int'(uio_out[7]), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_uo_out", int'(uo_out), 0);
    chk("abort_uio_out", int'(uio_out), 0);
    sbq.delete();
    model_reset();
    uio_in = {4'h0, 1'b1, 3'd2};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(cyc + 6);
    chk("held_strobe_ignored", int'(uio_out), 0);
    uio_in[3] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    issue(0, 50, 0, 0);
    issue(1, 60, 0, 0);
    issue(2, 0, 0, 0);
    chk("add_after_reset", int'(uo_out), 110);

    wait_cyc(cyc + 20);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_nishit0072e_seq_alu.md
TT_UM_NISHIT0072E_SEQ_ALU -- requirements
Module: tt_um_nishit0072e_seq_alu

Interface
REQ-001 Parameter WIDTH, default 7, legal 4..7; operand width in bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 ena  input  1  design-selected flag; no functional effect.
REQ-005 ui_in  input  8  [WIDTH-1:0] operand data; [7] hi_sel (0 shows result low half, 1 shows high half); other bits ignored.
REQ-006 uio_in  input  8  [2:0] opcode; [3] cmd strobe; [7:4] ignored.
REQ-007 uio_out  output  8  [7] busy, [6] done, [5] zero, [4] carry; [3:0] constant 0.
REQ-008 uio_oe  output  8  constant 8'hF0.
REQ-009 uo_out  output  8  hi_sel ? res_hi : res_lo, each WIDTH bits, zero-extended, combinational from registers.

Function
REQ-010 Opcodes: 0 LDA (A<=data), 1 LDB (B<=data), 2 ADD, 3 SUB (A-B), 4 AND, 5 XOR, 6 MUL (unsigned), 7 DIV (unsigned A/B).
REQ-011 Strobe passes two sync flops s1,s2 plus history s3; command accepted on a cycle with s2=1, s3=0, busy=0; opcode sampled from uio_in in that cycle.
REQ-012 Strobe high first sampled at edge k: single-cycle command completes at edge k+2 (regs, flags, done updated).
REQ-013 Rising strobe edge while busy=1 is discarded, not queued.
REQ-014 FSM states IDLE, RUN; IDLE->RUN on accepted MUL, or DIV with B!=0; RUN->IDLE after WIDTH iterations; all other commands stay IDLE.
REQ-015 MUL: shift-add, one bit per cycle; busy=1 for exactly WIDTH cycles after acceptance edge; result at edge k+2+WIDTH: {res_hi,res_lo}=A*B.
REQ-016 DIV: restoring, one quotient bit per cycle, same timing; res_lo=quotient, res_hi=remainder.
REQ-017 DIV with B=0: single-cycle; res_lo=all ones, res_hi=A, carry=1.
REQ-018 ADD/SUB/AND/XOR: res_lo=WIDTH-bit result; res_hi=0.
REQ-019 carry: ADD carry-out; SUB borrow (A<B); MUL res_hi!=0; DIV divide-by-zero; AND/XOR 0.
REQ-020 zero: set iff res_lo==0 and res_hi==0 (DIV: iff quotient==0).
REQ-021 LDA/LDB: update operand only; results and zero/carry held; done set.
REQ-022 done clears at any accepted command, sets on its completion; sticky otherwise.
REQ-023 A, B, results, flags unchanged during RUN except at completion edge.
REQ-024 hi_sel change affects uo_out same cycle, no state effect.

Reset
REQ-025 rst_n low: FSM=IDLE; A, B, res_hi, res_lo, iteration counter, sync flops = 0; busy, done, zero, carry = 0; uo_out=0.
REQ-026 Reset during RUN aborts immediately; no partial result survives.
REQ-027 Strobe held high through reset release is not a command until it falls and rises again.

Structure
REQ-028 Shared package tt_alu_pkg: opcode enum, FSM state enum, WIDTH default constant.
REQ-029 One sub-module alu_muldiv_unit: iterative MUL/DIV datapath with start/busy/done; top holds sync, decode, operand/result regs, flags.

Verification (WIDTH=7)
REQ-030 LDA 100, LDB 27, ADD -> res_lo=127, carry=0, zero=0, done at k+2.
REQ-031 A=5, B=9, SUB -> res_lo=124, carry=1; A=9, B=9, SUB -> res_lo=0, zero=1.
REQ-032 A=100, B=27, MUL -> busy 7 cycles, then res_lo=12, res_hi=21, carry=1; hi_sel toggles uo_out 12<->21.
REQ-033 A=100, B=27, DIV -> res_lo=3, res_hi=19 after 7 busy cycles; B=0 DIV -> res_lo=127, res_hi=100, carry=1, no busy.
REQ-034 Strobe pulse ADD during MUL busy -> ignored, MUL result intact, done once.
REQ-035 rst_n low mid-MUL -> all outputs 0, busy=0 immediately; next ADD after release works.
